// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning architectural HI/LO; sequences fixed-latency ops.
// Build option MD_DIV0_KEEP_EN: divide-by-zero leaves HI/LO unchanged at commit.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        E_Start,
  input  logic [1:0]  E_Type,
  input  logic [1:0]  E_Write,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDUse,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Stall,
  output logic        Done
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [1:0]    r_type;
  logic [31:0]   r_a, r_b, r_hi, r_lo, w_hi_nx, w_lo_nx;
  logic          r_done, w_done_nx, w_latch;

  // Signed divide done on magnitudes so 0x80000000 / -1 needs no special case.
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_mag_a, w_mag_b, w_uq, w_ur, w_sq, w_sr, w_dq, w_dr;

  always_comb begin
    w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    w_prod_u = {32'b0, r_a} * {32'b0, r_b};
    w_mag_a  = r_a[31] ? -r_a : r_a;
    w_mag_b  = r_b[31] ? -r_b : r_b;
    w_uq     = (w_mag_b == '0) ? '0 : w_mag_a / w_mag_b;
    w_ur     = (w_mag_b == '0) ? '0 : w_mag_a % w_mag_b;
    w_sq     = (r_a[31] ^ r_b[31]) ? -w_uq : w_uq;
    w_sr     = r_a[31] ? -w_ur : w_ur;
    w_dq     = (r_b == '0) ? '0 : r_a / r_b;
    w_dr     = (r_b == '0) ? '0 : r_a % r_b;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_done_nx  = 1'b0;
    w_latch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (E_Start) begin
          w_latch    = 1'b1;
          w_cnt_nx   = E_Type[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          w_state_nx = RUN;
        end else if (E_Write == 2'b01) begin
          w_hi_nx = E_A;
        end else if (E_Write == 2'b10) begin
          w_lo_nx = E_A;
        end
      end
      RUN: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - 1'b1;
        end else begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
          if (r_type[1] && (r_b == '0)) begin
`ifdef MD_DIV0_KEEP_EN
            w_hi_nx = r_hi;
            w_lo_nx = r_lo;
`else
            w_hi_nx = r_a;
            w_lo_nx = '1;
`endif
          end else begin
            case (r_type)
              2'b00:   {w_hi_nx, w_lo_nx} = w_prod_s;
              2'b01:   {w_hi_nx, w_lo_nx} = w_prod_u;
              2'b10:   begin w_hi_nx = w_sr; w_lo_nx = w_sq; end
              default: begin w_hi_nx = w_dr; w_lo_nx = w_dq; end
            endcase
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_type  <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_done  <= w_done_nx;
      if (w_latch) begin
        r_type <= E_Type;
        r_a    <= E_A;
        r_b    <= E_B;
      end
    end
  end

  assign HI    = r_hi;
  assign LO    = r_lo;
  assign Busy  = (r_state == RUN);
  assign Done  = r_done;
  assign Stall = D_MDUse & (Busy | E_Start);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized and directed checks of md_sched against a behavioural HI/LO model.
module tb_md_sched;
  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic        Clk = 1'b0, Reset = 1'b0;
  logic        E_Start = 1'b0, D_MDUse = 1'b0;
  logic [1:0]  E_Type = '0, E_Write = '0;
  logic [31:0] E_A = '0, E_B = '0;
  logic [31:0] HI, LO;
  logic        Busy, Stall, Done;

  int checks = 0, errors = 0, viol_run = 0, viol_idle = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  md_sched #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .Clk(Clk), .Reset(Reset), .E_Start(E_Start), .E_Type(E_Type), .E_Write(E_Write),
    .E_A(E_A), .E_B(E_B), .D_MDUse(D_MDUse), .HI(HI), .LO(LO),
    .Busy(Busy), .Stall(Stall), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Protocol monitor: issues while busy, or start and write together while idle.
  always @(posedge Clk) begin
    if (Reset) begin
      if (Busy && (E_Start || E_Write != 2'b00)) viol_run <= viol_run + 1;
      if (!Busy && E_Start && E_Write != 2'b00) viol_idle <= viol_idle + 1;
    end
  end

  function automatic void model(input logic [1:0] t, input logic [31:0] a, b, hi0, lo0,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, r64;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    hi = hi0;
    lo = lo0;
    if (t[1] && b == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
      hi = hi0; lo = lo0;
`else
      hi = a; lo = 32'hFFFF_FFFF;
`endif
    end else begin
      case (t)
        2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
        2'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
        2'd2: begin r64 = sa / sb; lo = r64[31:0]; r64 = sa % sb; hi = r64[31:0]; end
        default: begin lo = a / b; hi = a % b; end
      endcase
    end
  endfunction

  task automatic run_op(input logic [1:0] t, input logic [31:0] a, b, input bit inject);
    logic [31:0] eh, el;
    int n;
    n = t[1] ? DIV_C : MULT_C;
    model(t, a, b, m_hi, m_lo, eh, el);
    @(negedge Clk);
    E_Start = 1'b1; E_Type = t; E_A = a; E_B = b; E_Write = 2'b00; D_MDUse = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL start_stall got %b exp 1", Stall); end
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (i == 0) begin E_Start = 1'b0; E_A = $urandom; E_B = $urandom; end
      if (inject) begin E_Write = 2'b10; E_A = 32'h1234_5678; E_Start = (i == 1); end
      #1;
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0 || Stall !== 1'b1 || HI !== m_hi || LO !== m_lo) begin
        errors++;
        $display("FAIL busy_cycle%0d got busy=%b done=%b stall=%b hi=%h lo=%h exp 1 0 1 %h %h",
                 i, Busy, Done, Stall, HI, LO, m_hi, m_lo);
      end
    end
    @(negedge Clk);
    E_Start = 1'b0; E_Write = 2'b00;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b1) begin
      errors++; $display("FAIL commit_flags got busy=%b done=%b exp 0 1", Busy, Done);
    end
    checks++;
    if (HI !== eh || LO !== el) begin
      errors++; $display("FAIL result t=%0d a=%h b=%h got %h_%h exp %h_%h", t, a, b, HI, LO, eh, el);
    end
    m_hi = eh; m_lo = el;
    @(negedge Clk);
    #1;
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Stall !== 1'b0) begin
      errors++; $display("FAIL after_done got done=%b busy=%b stall=%b exp 0 0 0", Done, Busy, Stall);
    end
    D_MDUse = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b exp 0", HI, LO, Busy, Done);
    end
    D_MDUse = 1'b1; #1;
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b exp 0", Stall); end
    E_Start = 1'b1; #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL reset_stall_start got %b exp 1", Stall); end
    E_Start = 1'b0; D_MDUse = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_directed;
    run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_const got %h_%h exp ffffffff_fffffffa", HI, LO);
    end
    run_op(2'd3, 32'd7, 32'd2, 1'b0);
    checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      errors++; $display("FAIL divu_const got %h_%h exp 00000001_00000003", HI, LO);
    end
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_const got %h_%h exp ffffffff_fffffffd", HI, LO);
    end
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf got %h_%h exp 00000000_80000000", HI, LO);
    end
  endtask

  task automatic test_div0;
    logic [31:0] ph, pl;
    ph = HI; pl = LO;
    run_op(2'd3, 32'd9, 32'd0, 1'b0);
    checks++;
`ifdef MD_DIV0_KEEP_EN
    if (HI !== ph || LO !== pl) begin
      errors++; $display("FAIL div0_keep got %h_%h exp %h_%h", HI, LO, ph, pl);
    end
`else
    if (HI !== 32'd9 || LO !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div0 got %h_%h exp 00000009_ffffffff (prev %h_%h)", HI, LO, ph, pl);
    end
`endif
  endtask

  task automatic test_mtlo;
    @(negedge Clk);
    E_Write = 2'b10; E_A = 32'h1234_5678;
    @(negedge Clk);
    E_Write = 2'b00; #1;
    checks++;
    if (LO !== 32'h1234_5678 || Busy !== 1'b0) begin
      errors++; $display("FAIL mtlo got lo=%h busy=%b exp 12345678 0", LO, Busy);
    end
    m_lo = 32'h1234_5678;
    @(negedge Clk);
    E_Write = 2'b01; E_A = 32'hCAFE_F00D;
    @(negedge Clk);
    E_Write = 2'b00; #1;
    checks++;
    if (HI !== 32'hCAFE_F00D || LO !== 32'h1234_5678 || Busy !== 1'b0) begin
      errors++; $display("FAIL mthi got hi=%h lo=%h busy=%b exp cafef00d 12345678 0", HI, LO, Busy);
    end
    m_hi = 32'hCAFE_F00D;
  endtask

  task automatic test_run_write;
    int v0;
    v0 = viol_run;
    run_op(2'd3, 32'd100, 32'd7, 1'b1);
    #1;
    checks++;
    if (LO !== 32'd14 || HI !== 32'd2) begin
      errors++; $display("FAIL run_write_ignored got %h_%h exp 00000002_0000000e", HI, LO);
    end
    checks++;
    if (viol_run <= v0) begin
      errors++; $display("FAIL run_write_flag got %0d exp >%0d", viol_run, v0);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge Clk);
    E_Start = 1'b1; E_Type = 2'd1; E_A = 32'hDEAD_BEEF; E_B = 32'h1234_5679;
    @(negedge Clk);
    E_Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || Done !== 1'b0) begin
      errors++; $display("FAIL mid_reset got busy=%b hi=%h lo=%h done=%b exp 0", Busy, HI, LO, Done);
    end
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    Reset = 1'b1;
    run_op(2'd0, 32'h0001_0003, 32'hFFFF_0007, 1'b0);
  endtask

  task automatic test_random;
    logic [1:0] t, w;
    logic [31:0] a, b;
    int v0;
    v0 = viol_run;
    for (int it = 0; it < 24; it++) begin
      t = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(t, a, b, 1'b0);
      w = 2'($urandom_range(0, 2));
      if (w != 2'b00) begin
        @(negedge Clk);
        E_Write = w; E_A = $urandom;
        if (w == 2'b01) m_hi = E_A; else m_lo = E_A;
        @(negedge Clk);
        E_Write = 2'b00; #1;
        checks++;
        if (HI !== m_hi || LO !== m_lo || Busy !== 1'b0) begin
          errors++; $display("FAIL rand_write got %h_%h busy=%b exp %h_%h 0", HI, LO, Busy, m_hi, m_lo);
        end
      end
    end
    checks++;
    if (viol_run != v0 || viol_idle != 0) begin
      errors++; $display("FAIL protocol got run=%0d idle=%0d exp %0d 0", viol_run, viol_idle, v0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div0;
    test_mtlo;
    test_run_write;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
